// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequential 8x8 shift-add multiply-accumulate controller with valid/ready ports.
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   clear_i      synchronous abort: back to IDLE, accumulator and group state zeroed
//   len_i        pairs per group, sampled with the first pair (0 means 2^LEN_W)
//   in_valid_i   operand pair valid       in_ready_o   pair can be accepted (IDLE)
//   a_i, b_i     multiplicand, multiplier
//   out_valid_o  group result valid       out_ready_i  consumer takes result
//   result_o     accumulated sum mod 2^16 (0 unless out_valid_o)
//   ovf_o        sticky accumulate carry-out for the group (0 unless out_valid_o)
//   busy_o       controller not in IDLE

module adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};
endmodule

module mac_seq_ctrl #(
    parameter int LEN_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [15:0]       result_o,
    output logic              ovf_o,
    output logic              busy_o
);
    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    state_t             state, state_n;
    logic [15:0]        mcand, product, acc, add_a, add_b, add_sum;
    logic [DATA_W-1:0]  mplier;
    logic [2:0]         bit_cnt;
    logic [LEN_W-1:0]   pair_cnt, len_q;
    logic [LEN_W:0]     cnt_next, len_eff;
    logic               ovf, add_cout;

    // A latched length of zero stands for a full 2^LEN_W-pair group.
    assign cnt_next = {1'b0, pair_cnt} + (LEN_W+1)'(1);
    assign len_eff  = (len_q == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_q};

    // The single adder serves partial products in MUL and accumulation in ACC.
    assign add_a = (state == MUL) ? product : (state == ACC) ? acc : 16'd0;
    assign add_b = (state == MUL) ? mcand : (state == ACC) ? product : 16'd0;

    adder16 u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_n = state;
        if (clear_i)
            state_n = IDLE;
        else
            case (state)
                IDLE:    state_n = in_valid_i ? MUL : IDLE;
                MUL:     state_n = (bit_cnt == 3'd7) ? ACC : MUL;
                ACC:     state_n = (cnt_next == len_eff) ? DONE : IDLE;
                DONE:    state_n = out_ready_i ? IDLE : DONE;
                default: state_n = IDLE;
            endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            product  <= '0;
            acc      <= '0;
            bit_cnt  <= '0;
            pair_cnt <= '0;
            len_q    <= '0;
            ovf      <= 1'b0;
        end else begin
            state <= state_n;
            if (clear_i) begin
                mcand    <= '0;
                mplier   <= '0;
                product  <= '0;
                acc      <= '0;
                bit_cnt  <= '0;
                pair_cnt <= '0;
                len_q    <= '0;
                ovf      <= 1'b0;
            end else
                case (state)
                    IDLE: if (in_valid_i) begin
                        mcand   <= {{(16-DATA_W){1'b0}}, a_i};
                        mplier  <= b_i;
                        product <= '0;
                        bit_cnt <= '0;
                        if (pair_cnt == '0)
                            len_q <= len_i;
                    end
                    MUL: begin
                        if (mplier[0])
                            product <= add_sum;
                        mcand   <= mcand << 1;
                        mplier  <= mplier >> 1;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    ACC: begin
                        acc      <= add_sum;
                        ovf      <= ovf | add_cout;
                        pair_cnt <= cnt_next[LEN_W-1:0];
                    end
                    DONE: if (out_ready_i) begin
                        acc      <= '0;
                        ovf      <= 1'b0;
                        pair_cnt <= '0;
                    end
                    default: ;
                endcase
        end
    end

    assign in_ready_o  = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign out_valid_o = (state == DONE);
    assign result_o    = (state == DONE) ? acc : 16'd0;
    assign ovf_o       = (state == DONE) & ovf;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: table-driven and directed checks for mac_seq_ctrl.
module tb_mac_seq_ctrl;
    logic        clk = 0, rst = 1, clear = 0, in_valid = 0, out_ready = 0;
    logic [3:0]  len = 0;
    logic [7:0]  a = 0, b = 0;
    logic        in_ready, out_valid, ovf, busy;
    logic [15:0] result;
    int          tests = 0, fails = 0, cyc = 0, early = 0;

    typedef struct {
        logic [3:0]       len;
        int               n;
        logic [15:0][7:0] a;
        logic [15:0][7:0] b;
        logic [15:0]      res;
        logic             ovf;
    } vec_t;
    vec_t vecs[8];

    mac_seq_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .len_i       (len),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .ovf_o       (ovf),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] l, input int n, input logic [15:0] r, input logic o);
        vec_t v;
        v.len = l; v.n = n; v.res = r; v.ovf = o; v.a = '0; v.b = '0;
        return v;
    endfunction

    // Offers one pair, returns the cycle index in which it was accepted.
    task automatic feed(input logic [7:0] fa, input logic [7:0] fb, input logic [3:0] fl, output int acc_cyc);
        int w = 0;
        a = fa; b = fb; len = fl; in_valid = 1;
        while (!in_ready && w < 40) begin
            if (out_valid) early++;
            tick();
            w++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        acc_cyc = cyc;
        tick();
        in_valid = 0;
    endtask

    task automatic wait_valid(output int vcyc);
        int w = 0;
        while (!out_valid && w < 60) begin
            tick();
            w++;
        end
        if (!out_valid) chk("valid_timeout", 0, 1);
        vcyc = cyc;
    endtask

    task automatic handshake();
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("post_handshake_valid", out_valid, 0);
    endtask

    task automatic run_group(input vec_t v);
        int c, first, vc;
        early = 0;
        first = 0;
        for (int p = 0; p < v.n; p++) begin
            feed(v.a[p], v.b[p], v.len, c);
            if (p == 0) first = c;
        end
        wait_valid(vc);
        chk("early_valid", early, 0);
        chk("result", result, v.res);
        chk("ovf", ovf, v.ovf);
        chk("accept_to_valid", vc - c, 10);
        if (v.n == 16) chk("group_cycles", vc - first, 160);
        handshake();
    endtask

    initial begin
        int c, vc;
        vecs[0] = mk(1, 1, 15, 0);    vecs[0].a[0] = 3;   vecs[0].b[0] = 5;
        vecs[1] = mk(3, 3, 65026, 0); vecs[1].a[0] = 255; vecs[1].b[0] = 255;
        vecs[1].a[1] = 1; vecs[1].b[1] = 1; vecs[1].a[2] = 0; vecs[1].b[2] = 200;
        vecs[2] = mk(2, 2, 64514, 1); vecs[2].a[0] = 255; vecs[2].b[0] = 255;
        vecs[2].a[1] = 255; vecs[2].b[1] = 255;
        vecs[3] = mk(1, 1, 65025, 0); vecs[3].a[0] = 255; vecs[3].b[0] = 255;
        vecs[4] = mk(4, 4, 711, 0);   vecs[4].a[0] = 10;  vecs[4].b[0] = 20;
        vecs[4].a[1] = 0; vecs[4].b[1] = 0; vecs[4].a[2] = 255; vecs[4].b[2] = 1;
        vecs[4].a[3] = 2; vecs[4].b[3] = 128;
        vecs[5] = mk(0, 16, 16, 0);
        for (int i = 0; i < 16; i++) begin vecs[5].a[i] = 1; vecs[5].b[i] = 1; end
        vecs[6] = mk(1, 1, 256, 0);   vecs[6].a[0] = 128; vecs[6].b[0] = 2;
        vecs[7] = mk(2, 2, 510, 0);   vecs[7].a[0] = 1;   vecs[7].b[0] = 255;
        vecs[7].a[1] = 255; vecs[7].b[1] = 1;

        tick();
        tick();
        rst = 0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", ovf, 0);

        for (int i = 0; i < 8; i++) run_group(vecs[i]);

        // Backpressure: result held, no accept until the cycle after the handshake.
        feed(6, 7, 1, c);
        wait_valid(vc);
        a = 9; b = 9; len = 1; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_result", result, 42);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            tick();
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("bp_hs_valid", out_valid, 0);
        chk("bp_hs_busy", busy, 0);
        tick();
        in_valid = 0;
        chk("bp_accept_busy", busy, 1);
        wait_valid(vc);
        chk("bp_next_result", result, 81);
        handshake();

        // Clear in the 4th MUL cycle of the second pair of a group.
        feed(100, 100, 2, c);
        feed(50, 50, 2, c);
        tick(); tick(); tick();
        clear = 1;
        tick();
        clear = 0;
        chk("clr_busy", busy, 0);
        chk("clr_in_ready", in_ready, 1);
        chk("clr_valid", out_valid, 0);
        a = 5; b = 5; len = 1; in_valid = 1; clear = 1;
        tick();
        clear = 0; in_valid = 0;
        chk("clr_wins_busy", busy, 0);
        vecs[0] = mk(1, 1, 63, 0); vecs[0].a[0] = 7; vecs[0].b[0] = 9;
        run_group(vecs[0]);

        // Clear while a result is pending discards it.
        feed(2, 3, 1, c);
        wait_valid(vc);
        clear = 1; out_ready = 1;
        tick();
        clear = 0; out_ready = 0;
        chk("clr_done_valid", out_valid, 0);
        vecs[0] = mk(1, 1, 16, 0); vecs[0].a[0] = 4; vecs[0].b[0] = 4;
        run_group(vecs[0]);

        // Asynchronous reset while in ACC of the second pair.
        feed(10, 10, 2, c);
        feed(20, 20, 2, c);
        for (int i = 0; i < 8; i++) tick();
        chk("acc_busy", busy, 1);
        #1 rst = 1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_valid", out_valid, 0);
        chk("arst_result", result, 0);
        chk("arst_ovf", ovf, 0);
        #1 rst = 0;
        tick();
        vecs[0] = mk(1, 1, 1, 0); vecs[0].a[0] = 1; vecs[0].b[0] = 1;
        run_group(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
